// File: rtl/uart_stream_bridge.sv
// rtl/uart_stream_bridge.sv - Avalon master that turns a 16550 UART into a pair of byte streams
//
// Ports:
//   avc_c1_clk, avc_c1_reset       clock, synchronous active-high reset
//   avm_m1_address/writedata       register byte address (index << 2) and write data
//   avm_m1_write/read              command strobes, held while avm_m1_waitrequest is high
//   avm_m1_readdata                read data, valid the cycle after the accepted read
//   tx_data/tx_valid/tx_ready      inbound byte stream (to the UART transmitter)
//   rx_data/rx_valid/rx_ready      outbound byte stream (from the UART receiver)
//   init_done                      UART programming complete
//   rx_overrun                     sticky: LSR.OE seen or received data stalled in the UART
//   uart_irq                       UART interrupt, only used with UART_BRIDGE_IRQ_EN
//
// Build option: define UART_BRIDGE_IRQ_EN to poll on uart_irq / pending TX data
// instead of the free-running POLL_GAP timer.

module uart_stream_bridge_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty,
  output logic       last
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign last  = (count == (AW+1)'(1));
endmodule

module uart_stream_bridge #(
  parameter logic [15:0] DIVISOR    = 16'd27,
  parameter logic [7:0]  LCR_VALUE  = 8'h03,
  parameter logic [7:0]  FCR_VALUE  = 8'h07,
  parameter int          FIFO_DEPTH = 16,
  parameter int          TX_BURST   = 16,
  parameter int          POLL_GAP   = 4
) (
  input  logic       avc_c1_clk,
  input  logic       avc_c1_reset,
  output logic [4:0] avm_m1_address,
  output logic [7:0] avm_m1_writedata,
  output logic       avm_m1_write,
  output logic       avm_m1_read,
  input  logic [7:0] avm_m1_readdata,
  input  logic       avm_m1_waitrequest,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       init_done,
  output logic       rx_overrun,
  input  logic       uart_irq
);
  localparam int GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
  localparam int BW       = $clog2(TX_BURST + 1);

  typedef enum logic [3:0] {
    INIT_LCR1, INIT_DLL, INIT_DLM, INIT_LCR2, INIT_FCR,
    GAP, POLL, LSR_WAIT, RD_RBR, RBR_WAIT, WR_THR
  } state_t;

  state_t        state, state_n, gap_entry;
  logic          run;
  logic [15:0]   gap_cnt;
  logic [BW-1:0] burst_cnt;
  logic          gap_expire;
  logic          cmd_wr, cmd_rd;
  logic [4:0]    cmd_addr;
  logic [7:0]    cmd_data;
  logic          accepted;
  logic          set_ovr;
  logic          rx_push, rx_pop, rx_full, rx_empty, rx_unused_last;
  logic          tx_push, tx_pop, tx_full, tx_empty, tx_last;
  logic [7:0]    tx_head;

  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign rx_valid = !rx_empty;
  assign rx_pop   = !rx_empty && rx_ready;

  uart_stream_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(avc_c1_clk), .reset(avc_c1_reset), .push(tx_push), .push_data(tx_data),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty), .last(tx_last)
  );

  uart_stream_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(avc_c1_clk), .reset(avc_c1_reset), .push(rx_push), .push_data(avm_m1_readdata),
    .pop(rx_pop), .head(rx_data), .full(rx_full), .empty(rx_empty), .last(rx_unused_last)
  );

`ifdef UART_BRIDGE_IRQ_EN
  logic tx_tried;

  // tx_tried: a THR burst was attempted since the UART last reported THRE=0.
  always_ff @(posedge avc_c1_clk) begin
    if (avc_c1_reset)                                      tx_tried <= 1'b0;
    else if (state == LSR_WAIT && !avm_m1_readdata[5])     tx_tried <= 1'b0;
    else if (state == WR_THR)                              tx_tried <= 1'b1;
  end

  assign gap_entry  = GAP;
  assign gap_expire = uart_irq || (!tx_empty && !tx_tried) || (gap_cnt == 16'd1023);
`else
  logic unused_irq;
  assign unused_irq = uart_irq;
  // A zero gap skips the GAP state entirely.
  assign gap_entry  = (POLL_GAP == 0) ? POLL : GAP;
  assign gap_expire = (gap_cnt == 16'(GAP_LAST));
`endif

  // Command decode from the current state; run keeps every strobe low in the
  // cycle straight out of reset so nothing is driven while reset is asserted.
  always_comb begin
    cmd_wr   = 1'b0;
    cmd_rd   = 1'b0;
    cmd_addr = 5'h00;
    cmd_data = 8'h00;
    case (state)
      INIT_LCR1: begin cmd_wr = 1'b1; cmd_addr = 5'h0C; cmd_data = LCR_VALUE | 8'h80; end
      INIT_DLL:  begin cmd_wr = 1'b1; cmd_addr = 5'h00; cmd_data = DIVISOR[7:0];      end
      INIT_DLM:  begin cmd_wr = 1'b1; cmd_addr = 5'h04; cmd_data = DIVISOR[15:8];     end
      INIT_LCR2: begin cmd_wr = 1'b1; cmd_addr = 5'h0C; cmd_data = LCR_VALUE & 8'h7F; end
      INIT_FCR:  begin cmd_wr = 1'b1; cmd_addr = 5'h08; cmd_data = FCR_VALUE;         end
      POLL:      begin cmd_rd = 1'b1; cmd_addr = 5'h14;                               end
      RD_RBR:    begin cmd_rd = 1'b1; cmd_addr = 5'h00;                               end
      WR_THR:    begin cmd_wr = 1'b1; cmd_addr = 5'h00; cmd_data = tx_head;           end
      default: ;
    endcase
  end

  assign avm_m1_write     = run && cmd_wr;
  assign avm_m1_read      = run && cmd_rd;
  assign avm_m1_address   = run ? cmd_addr : 5'h00;
  assign avm_m1_writedata = run ? cmd_data : 8'h00;
  assign accepted         = (avm_m1_write || avm_m1_read) && !avm_m1_waitrequest;

  always_comb begin
    state_n = state;
    rx_push = 1'b0;
    tx_pop  = 1'b0;
    set_ovr = 1'b0;
    case (state)
      INIT_LCR1: if (accepted) state_n = INIT_DLL;
      INIT_DLL:  if (accepted) state_n = INIT_DLM;
      INIT_DLM:  if (accepted) state_n = INIT_LCR2;
      INIT_LCR2: if (accepted) state_n = INIT_FCR;
      INIT_FCR:  if (accepted) state_n = gap_entry;
      GAP:       if (gap_expire) state_n = POLL;
      POLL:      if (accepted) state_n = LSR_WAIT;
      LSR_WAIT: begin
        if (avm_m1_readdata[1]) set_ovr = 1'b1;
        if (avm_m1_readdata[0] && !rx_full) begin
          state_n = RD_RBR;
        end else begin
          // Data waiting in the UART but nowhere to put it: flag and move on to TX.
          if (avm_m1_readdata[0]) set_ovr = 1'b1;
          if (avm_m1_readdata[5] && !tx_empty) state_n = WR_THR;
          else                                 state_n = gap_entry;
        end
      end
      RD_RBR:    if (accepted) state_n = RBR_WAIT;
      RBR_WAIT: begin
        rx_push = 1'b1;
        state_n = POLL;
      end
      WR_THR: begin
        if (accepted) begin
          tx_pop = 1'b1;
          if (burst_cnt == BW'(TX_BURST - 1) || (tx_last && !tx_push)) state_n = gap_entry;
        end
      end
      default: state_n = INIT_LCR1;
    endcase
  end

  always_ff @(posedge avc_c1_clk) begin
    if (avc_c1_reset) begin
      state      <= INIT_LCR1;
      run        <= 1'b0;
      init_done  <= 1'b0;
      rx_overrun <= 1'b0;
      gap_cnt    <= '0;
      burst_cnt  <= '0;
    end else begin
      state     <= state_n;
      run       <= 1'b1;
      gap_cnt   <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
      burst_cnt <= (state == WR_THR) ? burst_cnt + BW'(accepted) : '0;
      if (state == INIT_FCR && accepted) init_done  <= 1'b1;
      if (set_ovr)                       rx_overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_stream_bridge.sv
// tb/tb_uart_stream_bridge.sv - directed bench for uart_stream_bridge with a 16550 register model
module tb_uart_stream_bridge;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] avm_m1_address;
  logic [7:0] avm_m1_writedata;
  logic       avm_m1_write, avm_m1_read;
  logic [7:0] avm_m1_readdata;
  logic       avm_m1_waitrequest;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       init_done, rx_overrun, uart_irq;

  uart_stream_bridge dut (
    .avc_c1_clk(clk), .avc_c1_reset(reset),
    .avm_m1_address(avm_m1_address), .avm_m1_writedata(avm_m1_writedata),
    .avm_m1_write(avm_m1_write), .avm_m1_read(avm_m1_read),
    .avm_m1_readdata(avm_m1_readdata), .avm_m1_waitrequest(avm_m1_waitrequest),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .init_done(init_done), .rx_overrun(rx_overrun), .uart_irq(uart_irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] addr; logic [7:0] data; } init_vec_t;
  typedef struct { int n; logic [7:0] din[4]; logic [7:0] dexp[4]; } tx_vec_t;
  typedef struct { bit wr; bit thr; bit rbr; logic [4:0] addr; logic [7:0] data; int cyc; } access_t;

  init_vec_t  init_tbl[5];
  tx_vec_t    tx_tbl[3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  access_t    acc_q[$];
  logic [7:0] thr_q[$];
  int         thr_cyc_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_got[$];
  int         rbr_cnt = 0;
  int         both_err = 0;
  bit         thre = 0, oe = 0, dlab = 0;
  bit         arm_stall = 0;
  int         stall_left = 0;
  logic [4:0] held_addr;
  logic [7:0] held_data;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // UART register model: decides waitrequest and logs accepted commands at the
  // falling edge, returns read data just after the following rising edge.
  access_t    a;
  bit         rd_pend;
  logic [7:0] rd_val;
  always begin
    @(negedge clk);
    if (stall_left > 0) begin
      check("thr_hold_stable", {avm_m1_write, avm_m1_address, avm_m1_writedata},
            {1'b1, held_addr, held_data});
      avm_m1_waitrequest = (stall_left > 1);
      stall_left--;
    end else if (arm_stall && avm_m1_write && avm_m1_address == 5'h00 && !dlab) begin
      held_addr = avm_m1_address;
      held_data = avm_m1_writedata;
      avm_m1_waitrequest = 1'b1;
      stall_left = 3;
      arm_stall = 0;
    end else begin
      avm_m1_waitrequest = 1'b0;
    end
    if (avm_m1_write && avm_m1_read) both_err++;
    rd_pend = 0;
    rd_val  = 8'h00;
    if ((avm_m1_write || avm_m1_read) && !avm_m1_waitrequest) begin
      a.wr   = avm_m1_write;
      a.addr = avm_m1_address;
      a.data = avm_m1_write ? avm_m1_writedata : 8'h00;
      a.cyc  = cyc;
      a.thr  = avm_m1_write && avm_m1_address == 5'h00 && !dlab;
      a.rbr  = avm_m1_read && avm_m1_address == 5'h00 && !dlab;
      if (avm_m1_write) begin
        if (avm_m1_address == 5'h0C) dlab = avm_m1_writedata[7];
        if (a.thr) begin
          thr_q.push_back(avm_m1_writedata);
          thr_cyc_q.push_back(cyc);
        end
      end else begin
        rd_pend = 1;
        if (avm_m1_address == 5'h14) begin
          rd_val = {1'b0, thre, thre, 3'b000, oe, rx_q.size() != 0};
          oe = 0;
        end else if (a.rbr) begin
          rbr_cnt++;
          if (rx_q.size() != 0) rd_val = rx_q.pop_front();
        end
      end
      acc_q.push_back(a);
    end
    @(posedge clk);
    cyc++;
    #1;
    avm_m1_readdata = rd_pend ? rd_val : 8'h00;
  end

  always @(negedge clk) begin
    if (rx_valid && rx_ready) rx_got.push_back(rx_data);
  end

  task automatic push_tx(input logic [7:0] b);
    @(posedge clk); #2;
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk); #2;
    tx_valid = 1'b0;
  endtask

  task automatic wait_thr(input int target);
    for (int i = 0; i < 400 && thr_q.size() < target; i++) @(negedge clk);
  endtask

  task automatic run_init_check(input int base);
    int rise;
    bit ok;
    ok = 0;
    rise = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (init_done) begin ok = 1; rise = cyc; end
    end
    check("init_done_rise", 32'(ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (acc_q.size() > base + i) begin
        check($sformatf("init_wr%0d_addr", i), {acc_q[base+i].wr, acc_q[base+i].addr},
              {1'b1, init_tbl[i].addr});
        check($sformatf("init_wr%0d_data", i), acc_q[base+i].data, init_tbl[i].data);
      end else begin
        check($sformatf("init_wr%0d_present", i), acc_q.size(), base + i + 1);
      end
    end
    if (acc_q.size() >= base + 5) check("init_done_latency", rise, acc_q[base+4].cyc + 1);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (acc_q.size() > base + 5) ok = 1;
    end
    check("first_poll_seen", 32'(ok), 32'd1);
    if (ok) begin
      check("first_poll_addr", {acc_q[base+5].wr, acc_q[base+5].addr}, {1'b0, 5'h14});
      check("first_poll_gap", acc_q[base+5].cyc, rise + 4);
    end
  endtask

  initial begin
    int base, t0, r0, rbr_i, thr_i;
    init_tbl[0] = '{5'h0C, 8'h83};
    init_tbl[1] = '{5'h00, 8'h1B};
    init_tbl[2] = '{5'h04, 8'h00};
    init_tbl[3] = '{5'h0C, 8'h03};
    init_tbl[4] = '{5'h08, 8'h07};
    tx_tbl[0].n = 3; tx_tbl[0].din = '{8'h41, 8'h42, 8'h43, 8'h00}; tx_tbl[0].dexp = '{8'h41, 8'h42, 8'h43, 8'h00};
    tx_tbl[1].n = 1; tx_tbl[1].din = '{8'hA5, 8'h00, 8'h00, 8'h00}; tx_tbl[1].dexp = '{8'hA5, 8'h00, 8'h00, 8'h00};
    tx_tbl[2].n = 4; tx_tbl[2].din = '{8'h00, 8'hFF, 8'h80, 8'h7E}; tx_tbl[2].dexp = '{8'h00, 8'hFF, 8'h80, 8'h7E};

    reset = 1'b1;
    avm_m1_readdata = 8'h00;
    avm_m1_waitrequest = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    uart_irq = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_write", avm_m1_write, 1'b0);
    check("rst_read", avm_m1_read, 1'b0);
    check("rst_addr_data", {avm_m1_address, avm_m1_writedata}, 13'h0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_overrun", rx_overrun, 1'b0);

    @(posedge clk); #2;
    reset = 1'b0;
    base = acc_q.size();
    run_init_check(base);

    for (int v = 0; v < 3; v++) begin
      t0 = thr_q.size();
      for (int i = 0; i < tx_tbl[v].n; i++) push_tx(tx_tbl[v].din[i]);
      @(posedge clk); #2; thre = 1;
      wait_thr(t0 + tx_tbl[v].n);
      check($sformatf("tx%0d_count", v), thr_q.size() - t0, tx_tbl[v].n);
      if (thr_q.size() >= t0 + tx_tbl[v].n) begin
        for (int i = 0; i < tx_tbl[v].n; i++)
          check($sformatf("tx%0d_byte%0d", v, i), thr_q[t0+i], tx_tbl[v].dexp[i]);
        check($sformatf("tx%0d_one_burst", v), thr_cyc_q[t0+tx_tbl[v].n-1] - thr_cyc_q[t0],
              tx_tbl[v].n - 1);
      end
      @(posedge clk); #2; thre = 0;
      repeat (10) @(posedge clk);
    end

    r0 = rbr_cnt;
    rx_got.delete();
    @(posedge clk); #2;
    for (int i = 0; i < 20; i++) rx_q.push_back(8'(8'h10 + i));
    repeat (150) @(negedge clk);
    check("rx_full_reads", rbr_cnt - r0, 16);
    check("rx_full_overrun", rx_overrun, 1'b1);
    check("rx_full_left_in_uart", rx_q.size(), 4);
    check("rx_full_valid", rx_valid, 1'b1);
    @(posedge clk); #2; rx_ready = 1'b1;
    for (int i = 0; i < 400 && rx_got.size() < 20; i++) @(negedge clk);
    check("rx_drain_count", rx_got.size(), 20);
    for (int i = 0; i < 20 && i < rx_got.size(); i++)
      check($sformatf("rx_byte%0d", i), rx_got[i], 8'(8'h10 + i));

    t0 = thr_q.size();
    push_tx(8'h51); push_tx(8'h52); push_tx(8'h53);
    @(posedge clk); #2; arm_stall = 1; thre = 1;
    wait_thr(t0 + 3);
    check("stall_consumed", 32'(arm_stall), 32'd0);
    check("stall_tx_count", thr_q.size() - t0, 3);
    if (thr_q.size() >= t0 + 3) begin
      check("stall_byte0", thr_q[t0], 8'h51);
      check("stall_byte1", thr_q[t0+1], 8'h52);
      check("stall_byte2", thr_q[t0+2], 8'h53);
    end
    @(posedge clk); #2; thre = 0;
    repeat (10) @(posedge clk);

    t0 = thr_q.size();
    for (int i = 0; i < 5; i++) push_tx(8'(8'h61 + i));
    @(posedge clk); #2; thre = 1;
    for (int i = 0; i < 300 && thr_q.size() < t0 + 2; i++) @(negedge clk);
    reset = 1'b1;
    check("reset_mid_burst", 32'(thr_q.size() - t0 < 5), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_rst_tx_ready", tx_ready, 1'b1);
    check("mid_rst_rx_valid", rx_valid, 1'b0);
    check("mid_rst_strobes", {avm_m1_write, avm_m1_read, init_done}, 3'b000);
    @(posedge clk); #2;
    reset = 1'b0;
    base = acc_q.size();
    t0 = thr_q.size();
    run_init_check(base);
    repeat (60) @(negedge clk);
    check("no_stale_thr", thr_q.size() - t0, 0);
    check("overrun_cleared", rx_overrun, 1'b0);

    @(posedge clk); #2;
    thre = 0; rx_ready = 1'b0; rx_got.delete();
    rx_q.push_back(8'h98);
    for (int i = 0; i < 200 && !rx_valid; i++) @(negedge clk);
    check("prio_rx_pending", rx_valid, 1'b1);
    push_tx(8'h71); push_tx(8'h72);
    t0 = thr_q.size();
    base = acc_q.size();
    @(posedge clk); #2;
    rx_q.push_back(8'h99); oe = 1; thre = 1;
    wait_thr(t0 + 2);
    rbr_i = -1;
    thr_i = -1;
    for (int i = base; i < acc_q.size(); i++) begin
      if (acc_q[i].rbr && rbr_i < 0) rbr_i = i;
      if (acc_q[i].thr && thr_i < 0) thr_i = i;
    end
    check("prio_rbr_seen", 32'(rbr_i >= 0), 32'd1);
    check("prio_rbr_before_thr", 32'(rbr_i < thr_i), 32'd1);
    check("prio_overrun", rx_overrun, 1'b1);
    if (thr_q.size() >= t0 + 2) begin
      check("prio_thr0", thr_q[t0], 8'h71);
      check("prio_thr1", thr_q[t0+1], 8'h72);
    end
    @(posedge clk); #2; rx_ready = 1'b1;
    for (int i = 0; i < 100 && rx_got.size() < 2; i++) @(negedge clk);
    check("prio_rx_count", rx_got.size(), 2);
    if (rx_got.size() >= 2) begin
      check("prio_rx0", rx_got[0], 8'h98);
      check("prio_rx1", rx_got[1], 8'h99);
    end

    check("no_rd_wr_overlap", both_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
